// File: rtl/id_stage_pipe.sv
// MIPS decode stage: instruction decode, 32-entry register file written from WB,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int DATA_W         = 32,
  parameter bit ZERO_EXT_LOGIC = 1'b1,
  parameter bit RF_BYPASS      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst_id,
  input  logic              valid_id,
  input  logic              flush,
  input  logic              hold,
  input  logic              RegWrite_wb,
  input  logic [4:0]        RegWriteAddr_wb,
  input  logic [DATA_W-1:0] RegWriteData_wb,
  output logic              stall_id,
  output logic              valid_ex,
  output logic              RegWrite_ex,
  output logic              RegDst_ex,
  output logic              MemtoReg_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              Branch_ex,
  output logic              ALUSrcB_ex,
  output logic [2:0]        ALUCode_ex,
  output logic [DATA_W-1:0] Imm_ex,
  output logic [DATA_W-1:0] RsData_ex,
  output logic [DATA_W-1:0] RtData_ex,
  output logic [4:0]        RsAddr_ex,
  output logic [4:0]        RtAddr_ex,
  output logic [4:0]        RdAddr_ex
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src_b;
    logic [2:0] alu_code;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } idex_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = inst_id[31:26];
  assign rs = inst_id[25:21];
  assign rt = inst_id[20:16];
  assign rd = inst_id[15:11];
  assign fn = inst_id[5:0];

  // ---------------- decode ----------------
  ctrl_t dec;
  logic  uses_rt;
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (fn)
          6'h20: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_code = ALU_ADD; end
          6'h22: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_code = ALU_SUB; end
          6'h24: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_code = ALU_AND; end
          6'h25: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_code = ALU_OR;  end
          6'h2A: begin dec.reg_write = 1'b1; dec.reg_dst = 1'b1; dec.alu_code = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_code = ALU_ADD; end
      OP_ANDI: begin dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_code = ALU_AND; end
      OP_ORI:  begin dec.reg_write = 1'b1; dec.alu_src_b = 1'b1; dec.alu_code = ALU_OR;  end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.alu_code   = ALU_ADD;
      end
      OP_SW: begin
        uses_rt       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_code  = ALU_ADD;
      end
      OP_BEQ: begin
        uses_rt      = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_code = ALU_SUB;
      end
      default: ;
    endcase
  end

  // ---------------- immediate ----------------
  logic [DATA_W-1:0] imm;
  always_comb begin
    imm = DATA_W'($signed(inst_id[15:0]));
    if (ZERO_EXT_LOGIC && (op == OP_ANDI || op == OP_ORI))
      imm = DATA_W'(inst_id[15:0]);
  end

  // ---------------- register file ----------------
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] rs_data, rt_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite_wb && RegWriteAddr_wb != 5'd0) begin
      rf[RegWriteAddr_wb] <= RegWriteData_wb;
    end
  end

  // Write-first bypass lets an instruction in ID see the value WB retires this cycle.
  always_comb begin
    rs_data = (rs == 5'd0) ? '0 : rf[rs];
    rt_data = (rt == 5'd0) ? '0 : rf[rt];
    if (RF_BYPASS && RegWrite_wb && RegWriteAddr_wb != 5'd0) begin
      if (RegWriteAddr_wb == rs) rs_data = RegWriteData_wb;
      if (RegWriteAddr_wb == rt) rt_data = RegWriteData_wb;
    end
  end

  // ---------------- load-use hazard ----------------
  idex_t ex;
  logic  haz;
  always_comb begin
    haz = valid_id && valid_ex && ex.ctrl.mem_read && (ex.rt != 5'd0) &&
          ((ex.rt == rs) || (uses_rt && ex.rt == rt));
  end

  assign stall_id = ~reset & ~flush & (hold | haz);

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex       <= '0;
      valid_ex <= 1'b0;
    end else if (hold) begin
      ex       <= ex;
      valid_ex <= valid_ex;
    end else if (haz) begin
      ex       <= '0;
      valid_ex <= 1'b0;
    end else begin
      ex.ctrl    <= valid_id ? dec : '0;
      ex.imm     <= imm;
      ex.rs_data <= rs_data;
      ex.rt_data <= rt_data;
      ex.rs      <= rs;
      ex.rt      <= rt;
      ex.rd      <= rd;
      valid_ex   <= valid_id;
    end
  end

  assign RegWrite_ex = ex.ctrl.reg_write;
  assign RegDst_ex   = ex.ctrl.reg_dst;
  assign MemtoReg_ex = ex.ctrl.mem_to_reg;
  assign MemRead_ex  = ex.ctrl.mem_read;
  assign MemWrite_ex = ex.ctrl.mem_write;
  assign Branch_ex   = ex.ctrl.branch;
  assign ALUSrcB_ex  = ex.ctrl.alu_src_b;
  assign ALUCode_ex  = ex.ctrl.alu_code;
  assign Imm_ex      = ex.imm;
  assign RsData_ex   = ex.rs_data;
  assign RtData_ex   = ex.rt_data;
  assign RsAddr_ex   = ex.rs;
  assign RtAddr_ex   = ex.rt;
  assign RdAddr_ex   = ex.rd;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one instance with defaults, one with
// RF_BYPASS=0 / ZERO_EXT_LOGIC=0, both driven from the same stimulus.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, valid_id, flush, hold, we;
  logic [31:0] inst_id, wd;
  logic [4:0]  wa;

  logic        a_stall, a_valid, a_rw, a_rd, a_m2r, a_mr, a_mw, a_br, a_srcb;
  logic [2:0]  a_alu;
  logic [31:0] a_imm, a_rsd, a_rtd;
  logic [4:0]  a_rsa, a_rta, a_rda;
  logic        b_stall, b_valid, b_rw, b_rd, b_m2r, b_mr, b_mw, b_br, b_srcb;
  logic [2:0]  b_alu;
  logic [31:0] b_imm, b_rsd, b_rtd;
  logic [4:0]  b_rsa, b_rta, b_rda;

  logic [9:0] a_ctl, b_ctl;
  assign a_ctl = {a_rw, a_rd, a_m2r, a_mr, a_mw, a_br, a_srcb, a_alu};
  assign b_ctl = {b_rw, b_rd, b_m2r, b_mr, b_mw, b_br, b_srcb, b_alu};

  // {RegWrite, RegDst, MemtoReg, MemRead, MemWrite, Branch, ALUSrcB, ALUCode}
  localparam logic [9:0] C_ADD  = 10'b1100000_000;
  localparam logic [9:0] C_ADDI = 10'b1000001_000;
  localparam logic [9:0] C_ANDI = 10'b1000001_010;
  localparam logic [9:0] C_ORI  = 10'b1000001_011;
  localparam logic [9:0] C_LW   = 10'b1011001_000;
  localparam logic [9:0] C_BEQ  = 10'b0000010_001;

  localparam logic [31:0] I_ADDI_M5 = 32'h2001FFFB; // addi $1,$0,-5
  localparam logic [31:0] I_ADD_430 = 32'h00602020; // add $4,$3,$0
  localparam logic [31:0] I_ADD_400 = 32'h00002020; // add $4,$0,$0
  localparam logic [31:0] I_ADD_470 = 32'h00E02020; // add $4,$7,$0
  localparam logic [31:0] I_LW2     = 32'h8C220000; // lw $2,0($1)
  localparam logic [31:0] I_ADD_522 = 32'h00422820; // add $5,$2,$2
  localparam logic [31:0] I_ADDI_67 = 32'h20E60001; // addi $6,$7,1
  localparam logic [31:0] I_SW2     = 32'hAC020004; // sw $2,4($0)
  localparam logic [31:0] I_ADDI_20 = 32'h20020001; // addi $2,$0,1
  localparam logic [31:0] I_ORI     = 32'h34018000; // ori $1,$0,0x8000
  localparam logic [31:0] I_ANDI    = 32'h3001FFFF; // andi $1,$0,0xFFFF
  localparam logic [31:0] I_BEQ     = 32'h10220003; // beq $1,$2,3
  localparam logic [31:0] I_BAD     = 32'hFC221234; // op 0x3F

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .inst_id(inst_id), .valid_id(valid_id),
    .flush(flush), .hold(hold), .RegWrite_wb(we), .RegWriteAddr_wb(wa),
    .RegWriteData_wb(wd), .stall_id(a_stall), .valid_ex(a_valid),
    .RegWrite_ex(a_rw), .RegDst_ex(a_rd), .MemtoReg_ex(a_m2r), .MemRead_ex(a_mr),
    .MemWrite_ex(a_mw), .Branch_ex(a_br), .ALUSrcB_ex(a_srcb), .ALUCode_ex(a_alu),
    .Imm_ex(a_imm), .RsData_ex(a_rsd), .RtData_ex(a_rtd),
    .RsAddr_ex(a_rsa), .RtAddr_ex(a_rta), .RdAddr_ex(a_rda)
  );

  id_stage_pipe #(.DATA_W(32), .ZERO_EXT_LOGIC(1'b0), .RF_BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .inst_id(inst_id), .valid_id(valid_id),
    .flush(flush), .hold(hold), .RegWrite_wb(we), .RegWriteAddr_wb(wa),
    .RegWriteData_wb(wd), .stall_id(b_stall), .valid_ex(b_valid),
    .RegWrite_ex(b_rw), .RegDst_ex(b_rd), .MemtoReg_ex(b_m2r), .MemRead_ex(b_mr),
    .MemWrite_ex(b_mw), .Branch_ex(b_br), .ALUSrcB_ex(b_srcb), .ALUCode_ex(b_alu),
    .Imm_ex(b_imm), .RsData_ex(b_rsd), .RtData_ex(b_rtd),
    .RsAddr_ex(b_rsa), .RtAddr_ex(b_rta), .RdAddr_ex(b_rda)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v);
    inst_id  = i;
    valid_id = v;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b1; flush = 1'b0;
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    drive(I_ADDI_M5, 1'b1);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    tick(); tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    n_cmp++; if (a_ctl !== 10'd0) begin n_err++; $display("FAIL reset_ctl: got %b want 0", a_ctl); end
    n_cmp++; if ({a_imm, a_rsd, a_rtd} !== 96'd0) begin n_err++; $display("FAIL reset_data: got %h %h %h want 0", a_imm, a_rsd, a_rtd); end
    n_cmp++; if ({a_rsa, a_rta, a_rda, b_valid} !== 16'd0) begin n_err++; $display("FAIL reset_addr: got %h %h %h %b want 0", a_rsa, a_rta, a_rda, b_valid); end
    reset = 1'b0; hold = 1'b0; we = 1'b0;
    drive(32'h0, 1'b0);
    tick();
  endtask

  task automatic test_addi();
    drive(I_ADDI_M5, 1'b1);
    tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", a_valid); end
    n_cmp++; if (a_ctl !== C_ADDI) begin n_err++; $display("FAIL addi_ctl: got %b want %b", a_ctl, C_ADDI); end
    n_cmp++; if (a_imm !== 32'hFFFFFFFB) begin n_err++; $display("FAIL addi_imm: got %h want fffffffb", a_imm); end
    n_cmp++; if (a_rta !== 5'd1) begin n_err++; $display("FAIL addi_rt: got %0d want 1", a_rta); end
    // valid_id=0 leaves controls cleared even for a decodable word
    drive(I_ADDI_M5, 1'b0);
    tick();
    n_cmp++; if ({a_valid, a_ctl} !== 11'd0) begin n_err++; $display("FAIL novalid_ctl: got %b/%b want 0", a_valid, a_ctl); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd3; wd = 32'h1234;
    drive(I_ADD_430, 1'b1);
    tick();
    we = 1'b0;
    n_cmp++; if (a_rsd !== 32'h1234) begin n_err++; $display("FAIL bypass_on: got %h want 1234", a_rsd); end
    n_cmp++; if (b_rsd !== 32'h0) begin n_err++; $display("FAIL bypass_off: got %h want 0", b_rsd); end
    n_cmp++; if (a_ctl !== C_ADD) begin n_err++; $display("FAIL add_ctl: got %b want %b", a_ctl, C_ADD); end
    drive(I_ADD_430, 1'b1);
    tick();
    n_cmp++; if (b_rsd !== 32'h1234) begin n_err++; $display("FAIL rf_read_later: got %h want 1234", b_rsd); end
    we = 1'b1; wa = 5'd0; wd = 32'hDEAD;
    drive(I_ADD_400, 1'b1);
    tick();
    we = 1'b0;
    n_cmp++; if (a_rsd !== 32'h0) begin n_err++; $display("FAIL r0_bypass: got %h want 0", a_rsd); end
    tick();
    n_cmp++; if ({a_rsd, b_rsd} !== 64'h0) begin n_err++; $display("FAIL r0_write: got %h %h want 0", a_rsd, b_rsd); end
  endtask

  task automatic test_load_use();
    drive(I_LW2, 1'b1);
    tick();
    n_cmp++; if (a_ctl !== C_LW) begin n_err++; $display("FAIL lw_ctl: got %b want %b", a_ctl, C_LW); end
    drive(I_ADD_522, 1'b1);
    n_cmp++; if ({a_stall, b_stall} !== 2'b11) begin n_err++; $display("FAIL lu_stall: got %b want 11", {a_stall, b_stall}); end
    tick();
    n_cmp++; if ({a_valid, a_ctl} !== 11'd0) begin n_err++; $display("FAIL lu_bubble: got %b/%b want 0", a_valid, a_ctl); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_one: got %b want 0", a_stall); end
    tick();
    n_cmp++; if ({a_valid, a_ctl, a_rda, a_rsa} !== {1'b1, C_ADD, 5'd5, 5'd2}) begin n_err++; $display("FAIL lu_issue: got %b/%b rd %0d rs %0d", a_valid, a_ctl, a_rda, a_rsa); end
    // independent consumer
    drive(I_LW2, 1'b1); tick();
    drive(I_ADDI_67, 1'b1);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_indep: got %b want 0", a_stall); end
    tick();
    n_cmp++; if ({a_valid, a_rta} !== {1'b1, 5'd6}) begin n_err++; $display("FAIL lu_indep_issue: got %b rt %0d", a_valid, a_rta); end
    // sw reads rt
    drive(I_LW2, 1'b1); tick();
    drive(I_SW2, 1'b1);
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL lu_sw: got %b want 1", a_stall); end
    tick();
    // addi only writes rt
    drive(I_LW2, 1'b1); tick();
    drive(I_ADDI_20, 1'b1);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_addi_rt: got %b want 0", a_stall); end
    tick();
  endtask

  task automatic test_flush_hold();
    drive(I_LW2, 1'b1); tick();
    flush = 1'b1;
    drive(I_ADD_522, 1'b1);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", a_stall); end
    tick();
    flush = 1'b0;
    n_cmp++; if ({a_valid, a_ctl, a_rsa} !== 16'd0) begin n_err++; $display("FAIL flush_bubble: got %b/%b rs %0d", a_valid, a_ctl, a_rsa); end
    drive(I_LW2, 1'b1); tick();
    hold = 1'b1;
    drive(I_ADD_522, 1'b1);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", c, a_stall); end
      tick();
      n_cmp++; if ({a_valid, a_ctl, a_rta, a_rsa} !== {1'b1, C_LW, 5'd2, 5'd1}) begin n_err++; $display("FAIL hold_keep[%0d]: got %b/%b rt %0d rs %0d", c, a_valid, a_ctl, a_rta, a_rsa); end
    end
    hold = 1'b0;
    #1;
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL hold_then_haz: got %b want 1", a_stall); end
    tick();
    n_cmp++; if ({a_valid, a_ctl, a_stall} !== 12'd0) begin n_err++; $display("FAIL hold_bubble: got %b/%b stall %b", a_valid, a_ctl, a_stall); end
    tick();
    n_cmp++; if ({a_valid, a_ctl} !== {1'b1, C_ADD}) begin n_err++; $display("FAIL hold_issue: got %b/%b", a_valid, a_ctl); end
  endtask

  task automatic test_imm_decode();
    drive(I_ORI, 1'b1); tick();
    n_cmp++; if (a_imm !== 32'h00008000) begin n_err++; $display("FAIL ori_zext: got %h want 00008000", a_imm); end
    n_cmp++; if (b_imm !== 32'hFFFF8000) begin n_err++; $display("FAIL ori_sext: got %h want ffff8000", b_imm); end
    n_cmp++; if (a_ctl !== C_ORI) begin n_err++; $display("FAIL ori_ctl: got %b want %b", a_ctl, C_ORI); end
    drive(I_ANDI, 1'b1); tick();
    n_cmp++; if ({a_ctl, a_imm} !== {C_ANDI, 32'h0000FFFF}) begin n_err++; $display("FAIL andi: got %b %h", a_ctl, a_imm); end
    drive(I_BEQ, 1'b1); tick();
    n_cmp++; if ({a_ctl, a_imm} !== {C_BEQ, 32'h3}) begin n_err++; $display("FAIL beq: got %b %h", a_ctl, a_imm); end
    drive(I_BAD, 1'b1); tick();
    n_cmp++; if ({a_valid, a_ctl} !== {1'b1, 10'd0}) begin n_err++; $display("FAIL bad_op: got %b/%b want 1/0", a_valid, a_ctl); end
  endtask

  task automatic test_reset_mid();
    we = 1'b1; wa = 5'd7; wd = 32'hABCD;
    drive(I_ADDI_M5, 1'b1); tick();
    we = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++; if ({a_valid, a_ctl, a_imm, a_rta} !== 48'd0) begin n_err++; $display("FAIL midreset: got %b/%b %h rt %0d", a_valid, a_ctl, a_imm, a_rta); end
    reset = 1'b0;
    drive(I_ADD_470, 1'b1); tick();
    n_cmp++; if ({a_rsd, b_rsd} !== 64'd0) begin n_err++; $display("FAIL midreset_rf: got %h %h want 0", a_rsd, b_rsd); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_flush_hold();
    test_imm_decode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
